sram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller driving the team's 16x8 dual-port SRAM (registered read, 1-cycle latency).

---
 rtl/sram_fifo_pkg.sv | 19 +
 rtl/sram_fifo_ctrl_if.sv | 20 ++
 rtl/sram_fifo_outbuf.sv | 62 ++++++
 rtl/sram_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_sram_fifo_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
// Shared widths and types for the SRAM-backed FIFO controller.
//   DW    : data width, matches the 16x8 SRAM word
//   AW    : SRAM address width
//   DEPTH : number of SRAM words (1 << AW)
//   addr_t / data_t / cnt_t : address, data and occupancy-count types
//                            (cnt_t holds up to DEPTH + 2)
// Optional feature macro used by the controller: SRAM_FIFO_WM_EN
// -----------------------------------------------------------------------------
package sram_fifo_pkg;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [AW+1:0] cnt_t;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl_if
// Byte stream valid/ready handshake used on both sides of the FIFO controller.
//   valid : producer has a byte
//   ready : consumer takes it (transfer on valid && ready)
//   data  : the byte
// Modports:
//   master : drives valid/data, samples ready
//   slave  : samples valid/data, drives ready
// -----------------------------------------------------------------------------
interface sram_fifo_ctrl_if;
    import sram_fifo_pkg::*;

    logic  valid;
    logic  ready;
    data_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sram_fifo_outbuf.sv
// -----------------------------------------------------------------------------
// sram_fifo_outbuf
// Two-entry FIFO-ordered skid buffer holding words already read out of the
// SRAM. Its head drives the consumer side directly.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din this cycle (SRAM read data arriving)
//   din        : SRAM read data
//   pop        : consumer took the head this cycle
//   head       : oldest buffered word
//   ob_cnt     : number of buffered words (0..2)
// -----------------------------------------------------------------------------
module sram_fifo_outbuf
    import sram_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  data_t      din,
    input  logic       pop,
    output data_t      head,
    output logic [1:0] ob_cnt
);
    data_t      slot_reg [2];
    logic [1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 2'd0;
        end else begin
            cnt_reg <= cnt_reg + {1'b0, load} - {1'b0, pop};
        end
    end

    // Slot 0 is always the head. Stale contents are harmless because they are
    // only visible when cnt_reg says so, hence no reset on the data path.
    always_ff @(posedge clk) begin
        case ({load, pop})
            2'b10: begin
                if (cnt_reg == 2'd0) slot_reg[0] <= din;
                else                 slot_reg[1] <= din;
            end
            2'b01: begin
                slot_reg[0] <= slot_reg[1];
            end
            2'b11: begin
                // Pop and load together: new word lands behind whatever
                // remains, so ordering is kept.
                if (cnt_reg == 2'd1) begin
                    slot_reg[0] <= din;
                end else begin
                    slot_reg[0] <= slot_reg[1];
                    slot_reg[1] <= din;
                end
            end
            default: ;
        endcase
    end

    assign head   = slot_reg[0];
    assign ob_cnt = cnt_reg;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
// FIFO controller in front of a 16x8 dual-port SRAM with registered read
// (1-cycle latency). Bytes come in on the slave stream, are written to the
// SRAM, and are prefetched into a 2-entry output buffer so the master stream
// is first-word-fall-through at one word per cycle.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   s (slave modport)      : input stream; s.ready == !full
//   m (master modport)     : output stream; m.valid == buffer non-empty
//   sram_wen / sram_addrw / sram_wdata : SRAM write port
//   sram_ren / sram_addrr / sram_rdata : SRAM read port
//   full                   : SRAM holds DEPTH words
//   empty                  : no words anywhere in the FIFO
//   count                  : words in SRAM + read in flight + output buffer
//   almost_full/almost_empty : watermarks, present only when SRAM_FIFO_WM_EN
//                              is defined (parameters AF_LEVEL / AE_LEVEL)
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
`ifdef SRAM_FIFO_WM_EN
#(
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
)
`endif
(
    input  logic     clk,
    input  logic     rst_n,
    sram_fifo_ctrl_if.slave  s,
    sram_fifo_ctrl_if.master m,
    output logic     sram_wen,
    output logic     sram_ren,
    output addr_t    sram_addrw,
    output addr_t    sram_addrr,
    output data_t    sram_wdata,
    input  data_t    sram_rdata,
    output logic     full,
    output logic     empty,
    output cnt_t     count
`ifdef SRAM_FIFO_WM_EN
    ,
    output logic     almost_full,
    output logic     almost_empty
`endif
);
    addr_t      wptr_reg;
    addr_t      rptr_reg;
    cnt_t       mem_cnt_reg;
    logic       rd_pend_reg;
    logic [1:0] ob_cnt;
    logic [1:0] pipe_cnt;
    data_t      ob_head;
    logic       push;
    logic       pop;
    logic       issue;

    assign full = (mem_cnt_reg == cnt_t'(DEPTH));

    // Writes are suppressed while reset is held so a producer that keeps
    // s.valid high through reset cannot touch the SRAM.
    assign push = rst_n && s.valid && !full;
    assign pop  = m.valid && m.ready;

    // Words already committed to leave the SRAM: one in flight plus those
    // buffered. Keeping it at most 2 (or 2 with a pop freeing a slot) is what
    // guarantees the output buffer can never overflow.
    assign pipe_cnt = {1'b0, rd_pend_reg} + ob_cnt;
    assign issue    = (mem_cnt_reg != '0) &&
                      ((pipe_cnt < 2'd2) || ((pipe_cnt == 2'd2) && pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            mem_cnt_reg <= '0;
            rd_pend_reg <= 1'b0;
        end else begin
            if (push)  wptr_reg <= wptr_reg + addr_t'(1);
            if (issue) rptr_reg <= rptr_reg + addr_t'(1);
            mem_cnt_reg <= mem_cnt_reg + cnt_t'(push) - cnt_t'(issue);
            rd_pend_reg <= issue;
        end
    end

    sram_fifo_outbuf u_outbuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (rd_pend_reg),
        .din    (sram_rdata),
        .pop    (pop),
        .head   (ob_head),
        .ob_cnt (ob_cnt)
    );

    assign s.ready = !full;
    assign m.valid = (ob_cnt != 2'd0);
    assign m.data  = ob_head;

    // push && issue cannot hit the same address: issue needs mem_cnt > 0 and
    // push needs mem_cnt < DEPTH, so wptr and rptr differ whenever both fire.
    assign sram_wen   = push;
    assign sram_ren   = issue;
    assign sram_addrw = wptr_reg;
    assign sram_addrr = rptr_reg;
    assign sram_wdata = s.data;

    assign count = mem_cnt_reg + cnt_t'(rd_pend_reg) + cnt_t'(ob_cnt);
    assign empty = (count == '0);

`ifdef SRAM_FIFO_WM_EN
    assign almost_full  = (count >= cnt_t'(AF_LEVEL));
    assign almost_empty = (count <= cnt_t'(AE_LEVEL));
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
// Self-checking bench for sram_fifo_ctrl with a behavioural 16x8 registered-read
// SRAM. The reference is a plain byte queue: every accepted byte is appended,
// every pop must return the queue head, and count must equal the queue size.
// Watermark checks are compiled in when SRAM_FIFO_WM_EN is defined.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;

    localparam int MAX_CNT  = DEPTH + 2;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  sram_wen;
    logic  sram_ren;
    addr_t sram_addrw;
    addr_t sram_addrr;
    data_t sram_wdata;
    data_t sram_rdata;
    logic  full;
    logic  empty;
    cnt_t  count;
`ifdef SRAM_FIFO_WM_EN
    logic  almost_full;
    logic  almost_empty;
`endif

    always #5 clk = ~clk;

    sram_fifo_ctrl_if s_if ();
    sram_fifo_ctrl_if m_if ();

    sram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s            (s_if),
        .m            (m_if),
        .sram_wen     (sram_wen),
        .sram_ren     (sram_ren),
        .sram_addrw   (sram_addrw),
        .sram_addrr   (sram_addrr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .full         (full),
        .empty        (empty),
        .count        (count)
`ifdef SRAM_FIFO_WM_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // Behavioural SRAM: synchronous write, registered read.
    data_t sram_mem [DEPTH];
    always @(posedge clk) begin
        if (sram_wen) sram_mem[sram_addrw] <= sram_wdata;
        if (sram_ren) sram_rdata <= sram_mem[sram_addrr];
    end

    int    n_checks = 0;
    int    n_pass   = 0;
    data_t model_q [$];
    logic  stall_flag = 1'b0;
    data_t stall_data;
    int    cyc = 0;
    int    n_pops = 0;
    int    n_push = 0;
    int    first_pop_cyc = -1;
    int    last_pop_cyc = -1;
    int    max_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: apply inputs, check handshake-time behaviour, update
    // the model, advance past the edge and check the resulting state.
    task automatic step(input logic sv, input data_t sd, input logic mr);
        s_if.valid  = sv;
        s_if.data   = sd;
        m_if.ready  = mr;
        #1;
        if (stall_flag) begin
            check("hold_valid", m_if.valid, 1);
            check("hold_data", m_if.data, stall_data);
        end
        if (sram_wen && sram_ren) check("collision", sram_addrw != sram_addrr, 1);
        if (m_if.valid && mr) begin
            if (model_q.size() == 0) check("pop_on_empty", m_if.valid, 0);
            else check("data", m_if.data, model_q.pop_front());
            n_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        stall_flag = m_if.valid && !mr;
        stall_data = m_if.data;
        if (sv && s_if.ready) begin
            model_q.push_back(sd);
            n_push++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("count", count, model_q.size());
        check("empty", empty, model_q.size() == 0);
        if (int'(count) > max_count) max_count = int'(count);
`ifdef SRAM_FIFO_WM_EN
        check("almost_full", almost_full, model_q.size() >= AF_LEVEL);
        check("almost_empty", almost_empty, model_q.size() <= AE_LEVEL);
`endif
    endtask

    task automatic drain(input string tag, input int budget);
        int guard;
        guard = 0;
        while (model_q.size() != 0 && guard < budget) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        check(tag, model_q.size(), 0);
    endtask

    initial begin
        s_if.valid = 1'b1;
        s_if.data  = 8'h77;
        m_if.ready = 1'b0;

        // Reset held with a producer pushing: nothing reaches the SRAM.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_wen", sram_wen, 0);
            check("rst_ren", sram_ren, 0);
            check("rst_s_ready", s_if.ready, 1);
            check("rst_empty", empty, 1);
            check("rst_m_valid", m_if.valid, 0);
            check("rst_count", count, 0);
`ifdef SRAM_FIFO_WM_EN
            check("rst_af", almost_full, 0);
            check("rst_ae", almost_empty, 1);
`endif
        end
        s_if.valid = 1'b0;
        rst_n = 1'b1;

        // Latency: first word visible after the third edge.
        step(1'b1, 8'hA5, 1'b0);
        check("lat_edge0", m_if.valid, 0);
        step(1'b0, 8'h00, 1'b0);
        check("lat_edge1", m_if.valid, 0);
        step(1'b0, 8'h00, 1'b0);
        check("lat_edge2", m_if.valid, 1);
        check("lat_data", m_if.data, 8'hA5);
        check("lat_count", count, 1);
        drain("lat_drain", 10);

        // Fill: 16 in SRAM plus 2 buffered, then backpressure.
        for (int i = 0; i < MAX_CNT; i++) step(1'b1, data_t'(i), 1'b0);
        check("fill_count", count, MAX_CNT);
        check("fill_s_ready", s_if.ready, 0);
        check("fill_full", full, 1);
        repeat (3) step(1'b1, 8'hEE, 1'b0);
        check("fill_hold_count", count, MAX_CNT);
        for (int i = 0; i < MAX_CNT; i++) begin
            step(1'b0, 8'h00, 1'b1);
        end
        check("fill_pops", n_push - n_pops, 0);
        check("fill_empty", empty, 1);

        // Streaming: 40 bytes, consumer always ready; no bubbles once primed.
        n_pops = 0;
        first_pop_cyc = -1;
        for (int i = 0; i < 40; i++) step(1'b1, data_t'(i * 7 + 3), 1'b1);
        drain("stream_drain", 20);
        check("stream_pops", n_pops, 40);
        check("stream_span", last_pop_cyc - first_pop_cyc, 39);

        // Random backpressure: 1000 bytes.
        begin
            int guard;
            int pushes0;
            int pops0;
            pushes0 = n_push;
            pops0 = n_pops;
            guard = 0;
            max_count = 0;
            while ((n_push - pushes0) < 1000 && guard < 20000) begin
                step($urandom_range(0, 99) < 60, data_t'($urandom), $urandom_range(0, 99) < 30);
                guard++;
            end
            check("bp_pushed", n_push - pushes0, 1000);
            guard = 0;
            while (model_q.size() != 0 && guard < 2000) begin
                step(1'b0, 8'h00, $urandom_range(0, 99) < 30);
                guard++;
            end
            check("bp_drained", model_q.size(), 0);
            check("bp_popped", n_pops - pops0, 1000);
            check("bp_max_count", max_count <= MAX_CNT, 1);
        end

        // Mid-operation reset with a read in flight and the buffer occupied.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        s_if.valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_m_valid", m_if.valid, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_s_ready", s_if.ready, 1);
        model_q.delete();
        stall_flag = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h3C, 1'b0);
        begin
            int guard;
            guard = 0;
            while (!m_if.valid && guard < 10) begin
                step(1'b0, 8'h00, 1'b0);
                guard++;
            end
        end
        check("post_rst_valid", m_if.valid, 1);
        check("post_rst_first", m_if.data, 8'h3C);
        drain("post_rst_drain", 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
